// File: rtl/calc_keypad_entry_pkg.sv
// Shared key codes, keypad layout and state encodings for the keypad entry path.
package calc_keypad_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_NEG   = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_EXEC  = 4'hF;

  // Physical layout, indexed by row*4+col:
  //   1 2 3 ENTER / 4 5 6 NEG / 7 8 9 CLR / (E) 0 EXEC (D)
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  typedef enum logic [1:0] {
    ST_A     = 2'd0,
    ST_B     = 2'd1,
    ST_OP    = 2'd2,
    ST_ISSUE = 2'd3
  } entry_state_t;

  typedef enum logic [1:0] {
    SC_SCAN,
    SC_PRESS_DB,
    SC_HELD,
    SC_RELEASE_DB
  } scan_state_t;

  // Two's-complement value of a sign/magnitude pair.
  function automatic logic [15:0] apply_sign(input logic [15:0] mag, input logic neg);
    return neg ? (~mag + 16'd1) : mag;
  endfunction

endpackage

// File: rtl/calc_keypad_entry_scanner.sv
// 4x4 keypad scanner: row synchronizer, column rotation and press/release debounce.
module keypad_scanner
  import calc_keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned DIV_W  = $clog2(SCAN_DIV + 1);
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
  // Synced rows lag a column change by two cycles; ignore them until settled.
  localparam int unsigned SETTLE = 2;

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [DB_W-1:0]  db_cnt;
  logic [3:0]       sample;
  scan_state_t      sc_state;

  logic       one_low;
  logic       all_high;
  logic       settled;
  logic [1:0] row_idx;
  logic [1:0] col_idx;

  // Decode the synced row pattern, the frozen sample and the driven column.
  always_comb begin
    one_low  = 1'b0;
    all_high = (row_sync == 4'b1111);
    settled  = (div_cnt >= DIV_W'(SETTLE));
    case (row_sync)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
    case (sample)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    case (col_out)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Synchronizer, column rotation and debounce FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta  <= '1;
      row_sync  <= '1;
      col_out   <= 4'b1110;
      div_cnt   <= '0;
      db_cnt    <= '0;
      sample    <= '1;
      sc_state  <= SC_SCAN;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      row_meta  <= row_in;
      row_sync  <= row_meta;
      key_valid <= 1'b0;
      case (sc_state)
        SC_SCAN: begin
          if (settled && one_low) begin
            sample   <= row_sync;
            db_cnt   <= DB_W'(1);
            sc_state <= SC_PRESS_DB;
          end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            col_out <= {col_out[2:0], col_out[3]};
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        SC_PRESS_DB: begin
          // A changed sample drops back to SCAN, which re-qualifies it from count 1.
          if (row_sync != sample) begin
            sc_state <= SC_SCAN;
          end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
            key_valid <= 1'b1;
            key_code  <= KEYMAP[{row_idx, col_idx}];
            sc_state  <= SC_HELD;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        SC_HELD: begin
          if (all_high) begin
            db_cnt   <= DB_W'(1);
            sc_state <= SC_RELEASE_DB;
          end
        end
        default: begin
          if (!all_high) begin
            sc_state <= SC_HELD;
          end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
            div_cnt  <= '0;
            sc_state <= SC_SCAN;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/calc_keypad_entry.sv
// Keypad front end of the calculator: operand/op-code entry and command handshake.
module calc_keypad_entry
  import calc_keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 20000,
  parameter int unsigned MAX_MAG      = 32767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [5:0]  sw_code,
  output logic [1:0]  entry_state,
  output logic [15:0] disp_value,
  output logic        key_err
);

  logic       key_valid;
  logic [3:0] key_code;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  entry_state_t state;
  logic [15:0]  acc;
  logic         neg;
  logic [15:0]  a_lat;
  logic [15:0]  b_lat;
  logic [2:0]   cat;
  logic [2:0]   sub;
  logic [1:0]   op_digits;

  logic [19:0]  acc_next;
  logic         mag_ok;
  logic         is_digit;

  assign entry_state = state;

  // Candidate accumulator for a digit key and its range check.
  always_comb begin
    acc_next = 20'(acc) * 20'd10 + 20'(key_code);
    mag_ok   = (acc_next <= 20'(MAX_MAG));
    is_digit = (key_code <= 4'd9);
  end

  // Entry FSM, accumulator datapath and command handshake register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_A;
      acc        <= '0;
      neg        <= 1'b0;
      a_lat      <= '0;
      b_lat      <= '0;
      cat        <= '0;
      sub        <= '0;
      op_digits  <= '0;
      op_a       <= '0;
      op_b       <= '0;
      sw_code    <= '0;
      cmd_valid  <= 1'b0;
      disp_value <= '0;
      key_err    <= 1'b0;
    end else begin
      key_err <= 1'b0;
      if (state == ST_ISSUE) begin
        if (cmd_valid && cmd_ready) begin
          cmd_valid  <= 1'b0;
          state      <= ST_A;
          acc        <= '0;
          neg        <= 1'b0;
          cat        <= '0;
          sub        <= '0;
          op_digits  <= '0;
          disp_value <= '0;
        end
      end else if (key_valid) begin
        if (key_code == KEY_CLR) begin
          state      <= ST_A;
          acc        <= '0;
          neg        <= 1'b0;
          cat        <= '0;
          sub        <= '0;
          op_digits  <= '0;
          disp_value <= '0;
        end else if (state == ST_OP) begin
          if (is_digit) begin
            if (op_digits == 2'd0 && key_code >= 4'd1 && key_code <= 4'd7) begin
              cat        <= key_code[2:0];
              op_digits  <= 2'd1;
              disp_value <= {10'b0, key_code[2:0], 3'b0};
            end else if (op_digits == 2'd1 && key_code <= 4'd7) begin
              sub        <= key_code[2:0];
              op_digits  <= 2'd2;
              disp_value <= {10'b0, cat, key_code[2:0]};
            end else begin
              key_err <= 1'b1;
            end
          end else if (key_code == KEY_EXEC) begin
            if (op_digits == 2'd2) begin
              state     <= ST_ISSUE;
              op_a      <= a_lat;
              op_b      <= b_lat;
              sw_code   <= {cat, sub};
              cmd_valid <= 1'b1;
            end else begin
              key_err <= 1'b1;
            end
          end else if (key_code == KEY_ENTER || key_code == KEY_NEG) begin
            key_err <= 1'b1;
          end
        end else begin
          if (is_digit) begin
            if (mag_ok) begin
              acc        <= acc_next[15:0];
              disp_value <= apply_sign(acc_next[15:0], neg);
            end else begin
              key_err <= 1'b1;
            end
          end else if (key_code == KEY_NEG) begin
            neg        <= ~neg;
            disp_value <= apply_sign(acc, ~neg);
          end else if (key_code == KEY_ENTER) begin
            if (state == ST_A) begin
              a_lat <= apply_sign(acc, neg);
              state <= ST_B;
            end else begin
              b_lat <= apply_sign(acc, neg);
              state <= ST_OP;
            end
            acc        <= '0;
            neg        <= 1'b0;
            cat        <= '0;
            sub        <= '0;
            op_digits  <= '0;
            disp_value <= '0;
          end else if (key_code == KEY_EXEC) begin
            key_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule
